// File: rtl/fetch_loader_ctrl.sv
// Instruction-fetch controller: loads program words from UART bytes into instruction
// memory and sequences the pipeline in free-run or single-step mode until halt.
module fetch_loader_ctrl #(
   parameter int          ADDR_WIDTH = 10,
   parameter logic [31:0] END_WORD   = 32'hFFFFFFFF
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [7:0]            rx_data,
   input  logic                  rx_done,
   input  logic                  halt,
   output logic                  im_we,
   output logic [ADDR_WIDTH-1:0] im_addr,
   output logic [31:0]           im_din,
   output logic                  pipe_enable,
   output logic                  pipe_restart,
   output logic                  loading,
   output logic                  busy,
   output logic [ADDR_WIDTH:0]   word_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_STEP_WAIT,
      S_STEP_EXEC,
      S_DONE
   } state_t;

   localparam logic [7:0] CMD_LOAD = 8'h4C;
   localparam logic [7:0] CMD_RUN  = 8'h52;
   localparam logic [7:0] CMD_STEP = 8'h53;
   localparam logic [7:0] CMD_NEXT = 8'h4E;

   localparam logic [ADDR_WIDTH:0] LAST_INDEX = {1'b0, {ADDR_WIDTH{1'b1}}};
   localparam logic [ADDR_WIDTH:0] ONE_WORD   = {{ADDR_WIDTH{1'b0}}, 1'b1};

   state_t      state_reg;
   logic [1:0]  byte_cnt_reg;
   logic [23:0] shift_reg;
   logic [31:0] word_full;

   // The fourth byte completes the word straight from rx_data (MSB-first assembly).
   assign word_full = {shift_reg, rx_data};

   assign loading = (state_reg == S_LOAD);
   assign busy    = (state_reg == S_RUN) || (state_reg == S_STEP_WAIT) ||
                    (state_reg == S_STEP_EXEC);

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg    <= S_IDLE;
         byte_cnt_reg <= 2'd0;
         shift_reg    <= 24'd0;
         im_we        <= 1'b0;
         im_addr      <= '0;
         im_din       <= 32'd0;
         pipe_enable  <= 1'b0;
         pipe_restart <= 1'b0;
         word_count   <= '0;
      end else begin
         im_we        <= 1'b0;
         pipe_restart <= 1'b0;
         case (state_reg)
            S_IDLE, S_DONE: begin
               pipe_enable <= 1'b0;
               if (rx_done) begin
                  if (rx_data == CMD_LOAD) begin
                     state_reg    <= S_LOAD;
                     im_addr      <= '0;
                     byte_cnt_reg <= 2'd0;
                     word_count   <= '0;
                  end else if (rx_data == CMD_RUN && word_count != '0) begin
                     state_reg    <= S_RUN;
                     pipe_restart <= 1'b1;
                     pipe_enable  <= 1'b1;
                  end else if (rx_data == CMD_STEP && word_count != '0) begin
                     state_reg    <= S_STEP_WAIT;
                     pipe_restart <= 1'b1;
                  end
               end
            end

            S_LOAD: begin
               pipe_enable <= 1'b0;
               if (rx_done) begin
                  shift_reg    <= {shift_reg[15:0], rx_data};
                  byte_cnt_reg <= byte_cnt_reg + 2'd1;
                  if (byte_cnt_reg == 2'd3) begin
                     if (word_full == END_WORD) begin
                        state_reg <= S_IDLE;
                     end else begin
                        // word_count doubles as the next write address while loading
                        im_we      <= 1'b1;
                        im_din     <= word_full;
                        im_addr    <= word_count[ADDR_WIDTH-1:0];
                        word_count <= word_count + ONE_WORD;
                        if (word_count == LAST_INDEX)
                           state_reg <= S_IDLE;
                     end
                  end
               end
            end

            S_RUN: begin
               if (halt) begin
                  state_reg   <= S_DONE;
                  pipe_enable <= 1'b0;
               end else begin
                  pipe_enable <= 1'b1;
               end
            end

            S_STEP_WAIT: begin
               pipe_enable <= 1'b0;
               if (rx_done) begin
                  if (rx_data == CMD_NEXT) begin
                     state_reg   <= S_STEP_EXEC;
                     pipe_enable <= 1'b1;
                  end else if (rx_data == CMD_RUN) begin
                     state_reg   <= S_RUN;
                     pipe_enable <= 1'b1;
                  end
               end
            end

            S_STEP_EXEC: begin
               pipe_enable <= 1'b0;
               state_reg   <= halt ? S_DONE : S_STEP_WAIT;
            end

            default: begin
               state_reg   <= S_IDLE;
               pipe_enable <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_loader_ctrl.sv
// Randomized bench for fetch_loader_ctrl; load results are predicted from the byte
// stream by a word-grouping model, run/step behaviour by per-cycle expectations.
module tb_fetch_loader_ctrl;

   localparam int AW    = 10;
   localparam int DEPTH = 1 << AW;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [7:0]    rx_data = 8'd0;
   logic          rx_done = 1'b0;
   logic          halt = 1'b0;
   logic          im_we;
   logic [AW-1:0] im_addr;
   logic [31:0]   im_din;
   logic          pipe_enable;
   logic          pipe_restart;
   logic          loading;
   logic          busy;
   logic [AW:0]   word_count;

   fetch_loader_ctrl #(.ADDR_WIDTH(AW), .END_WORD(32'hFFFFFFFF)) dut (
      .clock(clock), .reset(reset), .rx_data(rx_data), .rx_done(rx_done), .halt(halt),
      .im_we(im_we), .im_addr(im_addr), .im_din(im_din), .pipe_enable(pipe_enable),
      .pipe_restart(pipe_restart), .loading(loading), .busy(busy), .word_count(word_count)
   );

   always #5 clock = ~clock;

   int pass_cnt = 0;
   int total_cnt = 0;

   // Observation of write pulses and enable/restart activity, sampled on the falling edge
   logic [AW-1:0] wr_addr_q[$];
   logic [31:0]   wr_data_q[$];
   int            en_cycles = 0;
   int            en_rises = 0;
   int            restart_cnt = 0;
   logic          en_prev = 1'b0;

   always @(negedge clock) begin
      if (im_we) begin
         wr_addr_q.push_back(im_addr);
         wr_data_q.push_back(im_din);
      end
      if (pipe_restart) restart_cnt++;
      if (pipe_enable) en_cycles++;
      if (pipe_enable && !en_prev) en_rises++;
      en_prev = pipe_enable;
   end

   // Reference model for loads: group bytes MSB-first, stop at terminator or full memory
   logic [7:0]  byte_q[$];
   logic [31:0] exp_data_q[$];
   int          exp_done;

   task automatic build_expect();
      logic [31:0] w;
      exp_data_q.delete();
      exp_done = 0;
      for (int i = 0; i + 3 < byte_q.size(); i += 4) begin
         w = (32'(byte_q[i]) << 24) | (32'(byte_q[i+1]) << 16) |
             (32'(byte_q[i+2]) << 8) | 32'(byte_q[i+3]);
         if (w == 32'hFFFFFFFF) begin
            exp_done = 1;
            break;
         end
         exp_data_q.push_back(w);
         if (exp_data_q.size() == DEPTH) begin
            exp_done = 1;
            break;
         end
      end
   endtask

   function automatic logic [31:0] rand_word();
      logic [31:0] w;
      do w = $urandom; while (w == 32'hFFFFFFFF);
      return w;
   endfunction

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clock);
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data = b;
      rx_done = 1'b1;
      @(negedge clock);
      rx_done = 1'b0;
   endtask

   task automatic push_word(input logic [31:0] w);
      byte_q.push_back(w[31:24]);
      byte_q.push_back(w[23:16]);
      byte_q.push_back(w[15:8]);
      byte_q.push_back(w[7:0]);
   endtask

   // Sends 'L' plus byte_q with random gaps, then checks writes against the model
   task automatic do_load(input string tag, input int max_gap);
      int base;
      #2;
      base = wr_addr_q.size();
      send_byte(8'h4C);
      total_cnt++;
      if (loading !== 1'b1) $display("FAIL %s_enter_load got=%0b exp=1", tag, loading);
      else pass_cnt++;
      total_cnt++;
      if (word_count !== '0) $display("FAIL %s_count_clear got=%0d exp=0", tag, word_count);
      else pass_cnt++;
      foreach (byte_q[i]) begin
         send_byte(byte_q[i]);
         idle($urandom_range(0, max_gap));
      end
      idle(2);
      #2;
      build_expect();
      total_cnt++;
      if (wr_addr_q.size() - base !== exp_data_q.size())
         $display("FAIL %s_write_count got=%0d exp=%0d", tag, wr_addr_q.size() - base,
                  exp_data_q.size());
      else pass_cnt++;
      for (int i = 0; i < exp_data_q.size() && base + i < wr_addr_q.size(); i++) begin
         total_cnt++;
         if (wr_addr_q[base+i] !== AW'(i) || wr_data_q[base+i] !== exp_data_q[i])
            $display("FAIL %s_write%0d got=%h@%0d exp=%h@%0d", tag, i, wr_data_q[base+i],
                     wr_addr_q[base+i], exp_data_q[i], i);
         else pass_cnt++;
      end
      total_cnt++;
      if (word_count !== (AW+1)'(exp_data_q.size()))
         $display("FAIL %s_word_count got=%0d exp=%0d", tag, word_count, exp_data_q.size());
      else pass_cnt++;
      total_cnt++;
      if (loading !== (exp_done ? 1'b0 : 1'b1))
         $display("FAIL %s_loading_after got=%0b exp=%0b", tag, loading, !exp_done);
      else pass_cnt++;
      $display("load %s: %0d bytes, %0d words expected", tag, byte_q.size(), exp_data_q.size());
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle(3);
      total_cnt++;
      if ({im_we, pipe_enable, pipe_restart, loading, busy} !== 5'b0)
         $display("FAIL reset_flags got=%b exp=00000",
                  {im_we, pipe_enable, pipe_restart, loading, busy});
      else pass_cnt++;
      total_cnt++;
      if (im_addr !== '0 || im_din !== 32'd0 || word_count !== '0)
         $display("FAIL reset_data got=%0d/%h/%0d exp=0/0/0", im_addr, im_din, word_count);
      else pass_cnt++;
      reset = 1'b0;
      idle(1);
      $display("reset: applied and released");
   endtask

   task automatic test_zero_count(input string tag);
      int r0, e0;
      #2;
      r0 = restart_cnt;
      e0 = en_cycles;
      send_byte(8'h52);
      total_cnt++;
      if (pipe_restart !== 1'b0 || busy !== 1'b0)
         $display("FAIL %s_run_ignored got=restart%0b busy%0b exp=0,0", tag, pipe_restart, busy);
      else pass_cnt++;
      send_byte(8'h53);
      total_cnt++;
      if (pipe_restart !== 1'b0 || busy !== 1'b0)
         $display("FAIL %s_step_ignored got=restart%0b busy%0b exp=0,0", tag, pipe_restart, busy);
      else pass_cnt++;
      idle(3);
      #2;
      total_cnt++;
      if (restart_cnt - r0 !== 0 || en_cycles - e0 !== 0 || loading !== 1'b0)
         $display("FAIL %s_no_activity got=restarts%0d enables%0d loading%0b exp=0,0,0", tag,
                  restart_cnt - r0, en_cycles - e0, loading);
      else pass_cnt++;
      $display("zero-count %s: R and S sent with word_count=0", tag);
   endtask

   task automatic test_reset_mid_load();
      send_byte(8'h4C);
      send_byte(8'($urandom));
      send_byte(8'($urandom));
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      total_cnt++;
      if (loading !== 1'b0 || word_count !== '0)
         $display("FAIL midload_reset got=loading%0b count%0d exp=0,0", loading, word_count);
      else pass_cnt++;
      byte_q.delete();
      push_word(32'h00000001);
      do_load("midload", 1);
      byte_q.delete();
      push_word(32'hFFFFFFFF);
      foreach (byte_q[i]) send_byte(byte_q[i]);
      idle(1);
      total_cnt++;
      if (loading !== 1'b0 || word_count !== (AW+1)'(1))
         $display("FAIL midload_terminate got=loading%0b count%0d exp=0,1", loading, word_count);
      else pass_cnt++;
   endtask

   task automatic test_load_fixed();
      byte_q.delete();
      push_word(32'h12345678);
      push_word(32'h9ABCDEF0);
      push_word(32'hFFFFFFFF);
      do_load("fixed", 0);
   endtask

   task automatic test_load_random();
      for (int it = 0; it < 4; it++) begin
         byte_q.delete();
         for (int k = 0; k < $urandom_range(1, 7); k++) push_word(rand_word());
         push_word(32'hFFFFFFFF);
         // the last iteration holds a partial word through long gaps
         do_load($sformatf("rand%0d", it), (it == 3) ? 40 : 3);
      end
   endtask

   task automatic test_run();
      int r0, w0;
      logic [AW:0] wc0;
      #2;
      r0 = restart_cnt;
      w0 = wr_addr_q.size();
      wc0 = word_count;
      send_byte(8'h52);
      total_cnt++;
      if (pipe_restart !== 1'b1 || busy !== 1'b1)
         $display("FAIL run_restart got=restart%0b busy%0b exp=1,1", pipe_restart, busy);
      else pass_cnt++;
      for (int c = 1; c < 20; c++) begin
         rx_data = 8'($urandom);
         rx_done = 1'($urandom_range(0, 1));
         @(negedge clock);
         total_cnt++;
         if (pipe_enable !== 1'b1 || pipe_restart !== 1'b0 || busy !== 1'b1)
            $display("FAIL run_cycle%0d got=en%0b restart%0b busy%0b exp=1,0,1", c,
                     pipe_enable, pipe_restart, busy);
         else pass_cnt++;
      end
      halt = 1'b1;
      rx_data = 8'h4C;
      rx_done = 1'b1;
      @(negedge clock);
      halt = 1'b0;
      rx_done = 1'b0;
      total_cnt++;
      if (pipe_enable !== 1'b0 || busy !== 1'b0 || loading !== 1'b0)
         $display("FAIL run_halt got=en%0b busy%0b loading%0b exp=0,0,0", pipe_enable, busy,
                  loading);
      else pass_cnt++;
      idle(2);
      #2;
      total_cnt++;
      if (restart_cnt - r0 !== 1 || wr_addr_q.size() !== w0 || word_count !== wc0)
         $display("FAIL run_side_effects got=restarts%0d writes%0d count%0d exp=1,0,%0d",
                  restart_cnt - r0, wr_addr_q.size() - w0, word_count, wc0);
      else pass_cnt++;
      $display("run: 20 enabled cycles then halt");
   endtask

   task automatic test_step();
      int r0, e0, f0;
      logic [7:0] junk;
      #2;
      r0 = restart_cnt;
      send_byte(8'h53);
      total_cnt++;
      if (pipe_restart !== 1'b1 || pipe_enable !== 1'b0 || busy !== 1'b1)
         $display("FAIL step_enter got=restart%0b en%0b busy%0b exp=1,0,1", pipe_restart,
                  pipe_enable, busy);
      else pass_cnt++;
      idle(2);
      #2;
      e0 = en_cycles;
      f0 = en_rises;
      for (int n = 0; n < 3; n++) begin
         do junk = 8'($urandom); while (junk == 8'h4E || junk == 8'h52);
         send_byte(junk);
         idle($urandom_range(0, 2));
         send_byte(8'h4E);
         idle($urandom_range(1, 4));
      end
      #2;
      total_cnt++;
      if (en_cycles - e0 !== 3 || en_rises - f0 !== 3 || busy !== 1'b1)
         $display("FAIL step_pulses got=cycles%0d pulses%0d busy%0b exp=3,3,1",
                  en_cycles - e0, en_rises - f0, busy);
      else pass_cnt++;
      send_byte(8'h52);
      #2;
      e0 = en_cycles;
      total_cnt++;
      if (pipe_enable !== 1'b1 || pipe_restart !== 1'b0)
         $display("FAIL step_continue got=en%0b restart%0b exp=1,0", pipe_enable, pipe_restart);
      else pass_cnt++;
      idle(10);
      #2;
      total_cnt++;
      if (en_cycles - e0 !== 10 || restart_cnt - r0 !== 1)
         $display("FAIL step_continue_run got=cycles%0d restarts%0d exp=10,1",
                  en_cycles - e0, restart_cnt - r0);
      else pass_cnt++;
      halt = 1'b1;
      idle(1);
      halt = 1'b0;
      total_cnt++;
      if (busy !== 1'b0 || pipe_enable !== 1'b0)
         $display("FAIL step_run_halt got=busy%0b en%0b exp=0,0", busy, pipe_enable);
      else pass_cnt++;
      $display("step: three N pulses then continue and halt");
   endtask

   task automatic test_step_halt();
      send_byte(8'h53);
      halt = 1'b1;
      idle(3);
      total_cnt++;
      if (busy !== 1'b1 || pipe_enable !== 1'b0)
         $display("FAIL stepwait_halt_ignored got=busy%0b en%0b exp=1,0", busy, pipe_enable);
      else pass_cnt++;
      send_byte(8'h4E);
      total_cnt++;
      if (pipe_enable !== 1'b1)
         $display("FAIL stepexec_enable got=%0b exp=1", pipe_enable);
      else pass_cnt++;
      idle(1);
      halt = 1'b0;
      total_cnt++;
      if (busy !== 1'b0 || pipe_enable !== 1'b0)
         $display("FAIL stepexec_halt got=busy%0b en%0b exp=0,0", busy, pipe_enable);
      else pass_cnt++;
      $display("step-halt: halt during single step ends in done");
   endtask

   task automatic test_full();
      byte_q.delete();
      for (int k = 0; k < DEPTH; k++) push_word(rand_word());
      do_load("full", 0);
      #2;
      total_cnt++;
      if (wr_addr_q.size() == 0 || wr_addr_q[wr_addr_q.size()-1] !== AW'(DEPTH - 1))
         $display("FAIL full_last_addr got=%0d exp=%0d",
                  (wr_addr_q.size() == 0) ? -1 : int'(wr_addr_q[wr_addr_q.size()-1]), DEPTH - 1);
      else pass_cnt++;
      send_byte(8'h4C);
      total_cnt++;
      if (loading !== 1'b1 || word_count !== '0)
         $display("FAIL full_next_cmd got=loading%0b count%0d exp=1,0", loading, word_count);
      else pass_cnt++;
      for (int i = 0; i < 4; i++) send_byte(8'hFF);
      idle(1);
      total_cnt++;
      if (loading !== 1'b0 || word_count !== '0)
         $display("FAIL full_empty_load got=loading%0b count%0d exp=0,0", loading, word_count);
      else pass_cnt++;
   endtask

   initial begin
      @(negedge clock);
      test_reset();
      test_zero_count("initial");
      test_reset_mid_load();
      test_load_fixed();
      test_load_random();
      test_run();
      test_step();
      test_step_halt();
      test_full();
      test_zero_count("after_empty_load");
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
